adder_share_arbiter: RTL

ADDER_SHARE_ARBITER -- requirements
Module: adder_share_arbiter

---
 rtl/adder_share_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/adder_share_arbiter.sv
// Two requesters time-share one 3-bit adder through an IDLE/GRANT/DONE/RELEASE FSM.
// Define ADDER_ARB_ACCUM_EN to turn each sum register into a wrapping per-requester accumulator.
module adder_share_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [1:0] addend0,
  input  logic [1:0] addend1,
  input  logic       augend0,
  input  logic       augend1,
  output logic [1:0] grant_led,
  output logic       busy_led,
  output logic       done0,
  output logic       done1,
  output logic [2:0] sum0_led,
  output logic [2:0] sum1_led,
  output logic [1:0] state_dbg
);

  // Handshake: reqN is a level; once granted, doneN pulses for one cycle and the
  // grant is held in RELEASE until the winner lowers reqN.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_DONE    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t     state_q;
  logic       win_q;
  logic       rr_q;
  logic [1:0] opa_q;
  logic       opb_q;
  logic [1:0] grant_q;
  logic       done0_q;
  logic       done1_q;
  logic [2:0] sum0_q;
  logic [2:0] sum1_q;

  logic       pick_d;
  logic [2:0] sum_base_d;
  logic [2:0] sum_d;
  logic       win_req_d;

  // A tie goes to the round-robin pointer, otherwise to whoever is asking.
  assign pick_d = (req0 && req1) ? rr_q : req1;
  assign win_req_d = win_q ? req1 : req0;

`ifdef ADDER_ARB_ACCUM_EN
  assign sum_base_d = win_q ? sum1_q : sum0_q;
`else
  assign sum_base_d = 3'd0;
`endif

  assign sum_d = sum_base_d + {1'b0, opa_q} + {2'b00, opb_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      win_q   <= 1'b0;
      rr_q    <= 1'b0;
      opa_q   <= 2'd0;
      opb_q   <= 1'b0;
      grant_q <= 2'b00;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      sum0_q  <= 3'd0;
      sum1_q  <= 3'd0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req0 || req1) begin
            win_q   <= pick_d;
            grant_q <= pick_d ? 2'b10 : 2'b01;
            opa_q   <= pick_d ? addend1 : addend0;
            opb_q   <= pick_d ? augend1 : augend0;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (win_q) begin
            sum1_q  <= sum_d;
            done1_q <= 1'b1;
          end else begin
            sum0_q  <= sum_d;
            done0_q <= 1'b1;
          end
          state_q <= S_DONE;
        end
        S_DONE: begin
          rr_q    <= ~win_q;
          state_q <= S_RELEASE;
        end
        S_RELEASE: begin
          if (!win_req_d) begin
            grant_q <= 2'b00;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant_led = grant_q;
  assign busy_led  = (state_q != S_IDLE);
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign sum0_led  = sum0_q;
  assign sum1_led  = sum1_q;
  assign state_dbg = state_q;

endmodule
